// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush sequencer driving the stage-register enables and bubbles.
// Define PIPE_CTRL_MDU_STALL_EN to build the multi-cycle HI/LO occupancy stall in EX.
module pipeline_ctrl #(
  parameter int MD_CYCLES    = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_ld,
  input  logic [4:0] ex_write,
  input  logic       ex_tolh,
  input  logic       ex_branch_taken,
  input  logic       mem_syscall,
  input  logic       int_req,
  output logic       en_pc,
  output logic       en_if_id,
  output logic       en_id_ex,
  output logic       en_ex_mem,
  output logic       en_mem_wb,
  output logic       zero_if_id,
  output logic       zero_id_ex,
  output logic       zero_ex_mem,
  output logic       zero_mem_wb,
  output logic       pc_sel_vec,
  output logic       int_ack,
  output logic       halted
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_VECTOR = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [DW-1:0] r_drain_cnt;
  logic [DW-1:0] w_drain_cnt_nxt;
  logic          r_halt_first;
  logic          w_lu;
  logic          w_md;
  logic          w_md_apply;

  assign w_lu = ex_ld && (ex_write != 5'd0) &&
                ((id_use_rs && (id_rs == ex_write)) || (id_use_rt && (id_rt == ex_write)));

  assign halted = (r_state == S_HALT);

  always_comb begin
    en_pc           = 1'b1;
    en_if_id        = 1'b1;
    en_id_ex        = 1'b1;
    en_ex_mem       = 1'b1;
    en_mem_wb       = 1'b1;
    zero_if_id      = 1'b0;
    zero_id_ex      = 1'b0;
    zero_ex_mem     = 1'b0;
    zero_mem_wb     = 1'b0;
    pc_sel_vec      = 1'b0;
    int_ack         = 1'b0;
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    w_md_apply      = 1'b0;
    if (rst) begin
      en_pc       = 1'b0;
      en_if_id    = 1'b0;
      en_id_ex    = 1'b0;
      en_ex_mem   = 1'b0;
      en_mem_wb   = 1'b0;
      zero_if_id  = 1'b1;
      zero_id_ex  = 1'b1;
      zero_ex_mem = 1'b1;
      zero_mem_wb = 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          if (mem_syscall) begin
            en_pc       = 1'b0;
            zero_if_id  = 1'b1;
            zero_id_ex  = 1'b1;
            zero_ex_mem = 1'b1;
            w_state_nxt = S_HALT;
          end else if (w_md) begin
            en_pc       = 1'b0;
            en_if_id    = 1'b0;
            en_id_ex    = 1'b0;
            zero_ex_mem = 1'b1;
            w_md_apply  = 1'b1;
          end else if (ex_branch_taken) begin
            zero_if_id = 1'b1;
            zero_id_ex = 1'b1;
          end else if (w_lu) begin
            en_pc      = 1'b0;
            en_if_id   = 1'b0;
            zero_id_ex = 1'b1;
          end else if (int_req) begin
            w_state_nxt     = S_DRAIN;
            w_drain_cnt_nxt = DRAIN_LOAD;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
        // Fetch is frozen while older instructions retire; the PC keeps the resume address.
        S_DRAIN: begin
          en_pc      = 1'b0;
          zero_if_id = 1'b1;
          if (mem_syscall) begin
            zero_id_ex  = 1'b1;
            zero_ex_mem = 1'b1;
            w_state_nxt = S_HALT;
          end else if (w_md) begin
            en_if_id    = 1'b0;
            en_id_ex    = 1'b0;
            zero_ex_mem = 1'b1;
            w_md_apply  = 1'b1;
          end else begin
            if (ex_branch_taken) begin
              en_pc      = 1'b1;
              zero_id_ex = 1'b1;
            end else if (w_lu) begin
              en_if_id   = 1'b0;
              zero_id_ex = 1'b1;
            end else begin
              zero_id_ex = 1'b0;
            end
            if (r_drain_cnt != DW'(0)) begin
              w_drain_cnt_nxt = r_drain_cnt - DW'(1);
            end else if (ex_branch_taken || !w_lu) begin
              w_state_nxt = S_VECTOR;
            end else begin
              w_state_nxt = S_DRAIN;
            end
          end
        end
        S_VECTOR: begin
          pc_sel_vec  = 1'b1;
          en_pc       = 1'b1;
          int_ack     = 1'b1;
          zero_if_id  = 1'b1;
          w_state_nxt = S_RUN;
        end
        S_HALT: begin
          en_pc       = 1'b0;
          en_if_id    = 1'b0;
          en_id_ex    = 1'b0;
          en_ex_mem   = 1'b0;
          en_mem_wb   = r_halt_first;
          w_state_nxt = S_HALT;
        end
        default: begin
          w_state_nxt = S_RUN;
        end
      endcase
    end
  end

  // Sequencer state, drain counter and the one-shot syscall retirement flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_drain_cnt  <= DW'(0);
      r_halt_first <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_drain_cnt  <= w_drain_cnt_nxt;
      r_halt_first <= (r_state != S_HALT) && (w_state_nxt == S_HALT);
    end
  end

`ifdef PIPE_CTRL_MDU_STALL_EN
  localparam int MW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [MW-1:0] MD_LOAD = MW'(MD_CYCLES - 1);

  logic [MW-1:0] r_md_cnt;
  logic          r_md_done;
  logic          w_md_first;
  logic [MW-1:0] w_md_cur;

  // The first EX cycle of a HI/LO op sees the freshly loaded count so it stalls immediately.
  assign w_md_first = ex_tolh && !r_md_done && (r_md_cnt == MW'(0));
  assign w_md_cur   = w_md_first ? MD_LOAD : r_md_cnt;
  assign w_md       = ex_tolh && !r_md_done && (w_md_cur != MW'(0));

  // HI/LO occupancy counter; done holds the op in EX-complete until EX advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_md_cnt  <= MW'(0);
      r_md_done <= 1'b0;
    end else if (!ex_tolh) begin
      r_md_cnt  <= MW'(0);
      r_md_done <= 1'b0;
    end else if (w_md_apply) begin
      r_md_cnt  <= w_md_cur - MW'(1);
      r_md_done <= (w_md_cur == MW'(1));
    end else if (en_id_ex) begin
      r_md_cnt  <= MW'(0);
      r_md_done <= 1'b0;
    end else begin
      r_md_cnt  <= r_md_cnt;
      r_md_done <= r_md_done;
    end
  end
`else
  logic w_unused_mdu;

  assign w_md         = 1'b0;
  assign w_unused_mdu = ^{ex_tolh, w_md_apply, (MD_CYCLES > 0)};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed plus randomized stimulus against a cycle-level reference model,
// checked through an expected-output queue drained by an independent monitor.
module tb_pipeline_ctrl;
  localparam int MD_CYCLES    = 4;
  localparam int DRAIN_CYCLES = 3;
`ifdef PIPE_CTRL_MDU_STALL_EN
  localparam bit MDU_ON = 1'b1;
`else
  localparam bit MDU_ON = 1'b0;
`endif
  localparam int M_RUN = 0, M_DRAIN = 1, M_VECTOR = 2, M_HALT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_write = 5'd0;
  logic id_use_rs = 1'b0, id_use_rt = 1'b0, ex_ld = 1'b0, ex_tolh = 1'b0;
  logic ex_branch_taken = 1'b0, mem_syscall = 1'b0, int_req = 1'b0;
  logic en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic zero_if_id, zero_id_ex, zero_ex_mem, zero_mem_wb;
  logic pc_sel_vec, int_ack, halted;

  pipeline_ctrl #(.MD_CYCLES(MD_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_ld(ex_ld), .ex_write(ex_write), .ex_tolh(ex_tolh),
    .ex_branch_taken(ex_branch_taken), .mem_syscall(mem_syscall), .int_req(int_req),
    .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex), .en_ex_mem(en_ex_mem),
    .en_mem_wb(en_mem_wb), .zero_if_id(zero_if_id), .zero_id_ex(zero_id_ex),
    .zero_ex_mem(zero_ex_mem), .zero_mem_wb(zero_mem_wb), .pc_sel_vec(pc_sel_vec),
    .int_ack(int_ack), .halted(halted));

  always #5 clk = ~clk;

  // Reference model state: mode, cycles the HI/LO op has spent stalled in EX,
  // drain cycles completed, cycles already spent halted.
  int m_mode = M_RUN;
  int m_age = 0;
  int m_drain_done = 0;
  int m_halt_age = 0;

  logic [11:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Output order: en_pc en_if_id en_id_ex en_ex_mem en_mem_wb zero_if_id zero_id_ex zero_ex_mem zero_mem_wb pc_sel_vec int_ack halted
  task automatic model_step(output logic [11:0] e);
    bit lu, md, md_stalled, lu_stalls;
    bit epc, eifid, eidex, eexmem, ememwb, zifid, zidex, zexmem, zmemwb, vec, ack, hlt;
    epc = 1; eifid = 1; eidex = 1; eexmem = 1; ememwb = 1;
    zifid = 0; zidex = 0; zexmem = 0; zmemwb = 0; vec = 0; ack = 0;
    md_stalled = 0;
    lu = ex_ld && (ex_write != 5'd0) &&
         ((id_use_rs && id_rs == ex_write) || (id_use_rt && id_rt == ex_write));
    md = MDU_ON && ex_tolh && (m_age < MD_CYCLES - 1);
    hlt = (m_mode == M_HALT);
    if (rst) begin
      e = {5'b00000, 4'b1111, 3'b000};
      m_mode = M_RUN; m_age = 0; m_drain_done = 0; m_halt_age = 0;
      return;
    end
    case (m_mode)
      M_RUN: begin
        if (mem_syscall) begin
          epc = 0; zifid = 1; zidex = 1; zexmem = 1; m_mode = M_HALT; m_halt_age = 0;
        end else if (md) begin
          epc = 0; eifid = 0; eidex = 0; zexmem = 1; md_stalled = 1;
        end else if (ex_branch_taken) begin
          zifid = 1; zidex = 1;
        end else if (lu) begin
          epc = 0; eifid = 0; zidex = 1;
        end else if (int_req) begin
          m_mode = M_DRAIN; m_drain_done = 0;
        end
      end
      M_DRAIN: begin
        epc = 0; zifid = 1;
        if (mem_syscall) begin
          zidex = 1; zexmem = 1; m_mode = M_HALT; m_halt_age = 0;
        end else if (md) begin
          eifid = 0; eidex = 0; zexmem = 1; md_stalled = 1;
        end else begin
          lu_stalls = lu && !ex_branch_taken;
          if (ex_branch_taken) begin
            epc = 1; zidex = 1;
          end else if (lu) begin
            eifid = 0; zidex = 1;
          end
          if (m_drain_done >= DRAIN_CYCLES - 1) begin
            if (!lu_stalls) m_mode = M_VECTOR;
          end else begin
            m_drain_done++;
          end
        end
      end
      M_VECTOR: begin
        vec = 1; epc = 1; ack = 1; zifid = 1; m_mode = M_RUN;
      end
      default: begin
        epc = 0; eifid = 0; eidex = 0; eexmem = 0;
        ememwb = (m_halt_age == 0);
        m_halt_age++;
      end
    endcase
    if (!ex_tolh) m_age = 0;
    else if (md_stalled) m_age++;
    else if (eidex) m_age = 0;
    e = {epc, eifid, eidex, eexmem, ememwb, zifid, zidex, zexmem, zmemwb, vec, ack, hlt};
  endtask

  task automatic drive(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                       input bit urs, input bit urt, input bit ld, input logic [4:0] wr,
                       input bit tolh, input bit br, input bit sys, input bit irq);
    logic [11:0] e;
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    ex_ld = ld; ex_write = wr; ex_tolh = tolh; ex_branch_taken = br;
    mem_syscall = sys; int_req = irq;
    model_step(e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
  endtask

  // Monitor: the DUT presents outputs every cycle; compare mid-cycle against the queued expectation.
  always @(negedge clk) begin
    logic [11:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, zero_if_id, zero_id_ex,
           zero_ex_mem, zero_mem_wb, pc_sel_vec, int_ack, halted};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs check#%0d t=%0t: got %b expected %b", checks, $time, a, e);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    bit r, tolh;
    drive(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
    drive(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
    idle(2);
    // load-use on rs, then the same with ex_write==0
    drive(0, 5'd5, 5'd1, 1, 0, 1, 5'd5, 0, 0, 0, 0);
    drive(0, 5'd0, 5'd1, 1, 0, 1, 5'd0, 0, 0, 0, 0);
    drive(0, 5'd2, 5'd7, 0, 1, 1, 5'd7, 0, 0, 0, 0);
    // branch together with load-use
    drive(0, 5'd5, 5'd1, 1, 0, 1, 5'd5, 0, 1, 0, 0);
    idle(1);
    // HI/LO op held in EX
    for (int i = 0; i < MD_CYCLES; i++) drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0);
    idle(2);
    // interrupt pulse, full drain and vector
    drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1);
    idle(DRAIN_CYCLES + 3);
    // interrupt with a branch during drain
    drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1);
    idle(1);
    drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0);
    idle(DRAIN_CYCLES + 2);
    // syscall during drain
    drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1);
    idle(1);
    drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0);
    drive(0, 5'd3, 5'd3, 1, 1, 1, 5'd3, 0, 1, 0, 1);
    idle(3);
    drive(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
    idle(1);
    // reset in the middle of an MDU stall, then the op restarts from scratch
    drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0);
    drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0);
    drive(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0);
    for (int i = 0; i < MD_CYCLES + 1; i++) drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0);
    idle(1);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = ((m_mode == M_HALT) && (m_halt_age >= 3)) || ($urandom_range(0, 199) == 0);
      tolh = (m_age > 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 7) == 0);
      drive(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)), tolh,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 11) == 0));
    end
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never compared, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Drives the load-enable (`en_*`) and bubble-insert (`zero_*`) inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. Resolves load-use hazards, taken branches, multi-cycle HI/LO (mult/div) occupancy in EX, syscall halt and interrupt entry. Each stage register gives `zero` priority over enable, loads when enable=1, and holds when enable=0.

## Interface
- `MD_CYCLES`, default 4: total cycles a HI/LO-writing op occupies EX (≥1).
- `DRAIN_CYCLES`, default 3: cycles spent draining ID/EX/MEM before the interrupt vector.
- `clk` in 1: the single clock; all state on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `id_rs`, `id_rt` in 5: source register indices of the instruction in ID.
- `id_use_rs`, `id_use_rt` in 1: ID actually reads rs / rt.
- `ex_ld` in 1: instruction in EX is a load.
- `ex_write` in 5: destination register of the instruction in EX.
- `ex_tolh` in 1: instruction in EX writes HI/LO.
- `ex_branch_taken` in 1: branch/jump in EX redirects the PC this cycle.
- `mem_syscall` in 1: syscall in MEM.
- `int_req` in 1: level interrupt request.
- `en_pc`, `en_if_id`, `en_id_ex`, `en_ex_mem`, `en_mem_wb` out 1: stage load enables.
- `zero_if_id`, `zero_id_ex`, `zero_ex_mem`, `zero_mem_wb` out 1: stage flushes.
- `pc_sel_vec` out 1: the PC loads the exception vector this cycle.
- `int_ack` out 1: one-cycle interrupt acknowledge.
- `halted` out 1: the core is halted by a syscall.

## Operation
- State machine: RUN, DRAIN, VECTOR, HALT. Counters: `drain_cnt` and `md_cnt`, each sized by clog2 of its parameter. Flag: `md_done`.
- Default outputs: every `en_*`=1, every `zero_*`=0, `pc_sel_vec`=0, `int_ack`=0.
- Load-use hazard (`lu`) = `ex_ld` && `ex_write`≠0 && ((`id_use_rs` && `id_rs`==`ex_write`) || (`id_use_rt` && `id_rt`==`ex_write`)).
- MDU stall (`md`) = `ex_tolh` && !`md_done` && `md_cnt`≠0.
  - On the first EX cycle of a HI/LO op, `md_cnt` loads MD_CYCLES−1.
  - `md_cnt` decrements on each subsequent cycle.
  - `md_done` sets when `md_cnt` reaches 0 and clears when EX advances.
- Priority in RUN, highest first:
  1. `mem_syscall`: `zero_if_id`=`zero_id_ex`=`zero_ex_mem`=1, `en_pc`=0, then go to HALT.
  2. `md`: `en_pc`=`en_if_id`=`en_id_ex`=0, `zero_ex_mem`=1.
  3. `ex_branch_taken`: `zero_if_id`=`zero_id_ex`=1 with enables at default.
  4. `lu`: `en_pc`=`en_if_id`=0, `zero_id_ex`=1.
  5. `int_req`: no outputs change this cycle; `drain_cnt`←DRAIN_CYCLES−1, go to DRAIN.
- DRAIN:
  - `en_pc`=0 and `zero_if_id`=1; the downstream stages keep retiring.
  - `ex_branch_taken` forces `en_pc`=1 for that cycle, so the PC holds the correct resume address.
  - `md` and `lu` stall exactly as in RUN; `drain_cnt` does not decrement while `md` is high.
  - At `drain_cnt`==0 with no stall, go to VECTOR.
  - `mem_syscall` still wins and goes to HALT.
- VECTOR, one cycle: `pc_sel_vec`=1, `en_pc`=1, `int_ack`=1, `zero_if_id`=1, then return to RUN. CP0 captures EPC from the PC in this cycle.
- HALT: all `en_*`=0 except `en_mem_wb`=1 for the syscall's retirement cycle only. `halted`=1. Only `rst` exits HALT.
- `ex_write`==0 never causes a hazard.

## Timing
- Reset (asynchronous, immediate) while `rst`=1:
  - state=RUN, both counters=0, `md_done`=0.
  - Every `en_*`=0 and every `zero_*`=1.
  - `pc_sel_vec`=0, `int_ack`=0, `halted`=0.
- Reset mid-DRAIN or mid-MDU abandons the sequence with no ack.
- Hazard outputs are combinational from inputs and state, in the same cycle. State and counters update on the posedge.
- Load-use costs 1 bubble; a taken branch costs 2 flushed slots; a HI/LO op costs MD_CYCLES−1 stall cycles.
- Interrupt latency: `int_req` high in RUN → `int_ack` after 1 + DRAIN_CYCLES + (MDU stall) cycles.
- `int_req` dropping after entering DRAIN does not abort the sequence.
- `halted` rises on the edge after `mem_syscall`.

## Configuration
- `PIPE_CTRL_MDU_STALL_EN`:
  - Defined: `md_cnt` and `md_done` are built and MDU stalls behave as specified.
  - Undefined: `md` is tied to 0, the counter logic is removed, and HI/LO ops take one EX cycle. MD_CYCLES is ignored.

## Test plan
- Load-use: `ex_ld`=1, `ex_write`=5, `id_rs`=5, `id_use_rs`=1 → one cycle with `en_pc`=`en_if_id`=0, `zero_id_ex`=1. The same case with `ex_write`=0 → no stall.
- Branch and load-use together: `ex_branch_taken`=1 with `lu`=1 → `zero_if_id`=`zero_id_ex`=1, `en_pc`=1 (branch wins).
- MDU, macro defined, MD_CYCLES=4: `ex_tolh` held → exactly 3 cycles of `en_id_ex`=0 with `zero_ex_mem`=1, then EX advances. With the macro undefined → 0 stall cycles.
- Interrupt, DRAIN_CYCLES=3: `int_req` pulse in RUN → `zero_if_id`=1 for 3 cycles, then `pc_sel_vec`=`int_ack`=1 for exactly 1 cycle. A branch during DRAIN → `en_pc`=1 in that cycle only.
- Syscall during DRAIN: `mem_syscall`=1 → state HALT and `halted`=1 on the next edge, with no `int_ack`. Enables stay 0 until reset.
- Reset: assert `rst` mid-MDU stall → every `zero_*`=1 and every `en_*`=0 asynchronously. After release, `md_cnt`=0 and state=RUN.
